// File: rtl/x2_mul_reduce_if.sv
// Bundle/result bus for the multiplier reduce stage: X1->X2 FIFO side, flush/stall
// control and the result buffer head. master = upstream/consumer side, slave = reduce stage.
interface x2_mul_reduce_if #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned NPP  = 2,
   parameter int unsigned TAGW = 6
);
   logic [NPP*2*XLEN-1:0] RES_RX1;
   logic                  SELECT_MSB_RX1;
   logic [TAGW-1:0]       TAG_RX1;
   logic                  X1X2_EMPTY_SX1;
   logic                  X1X2_POP_SX2;
   logic                  FLUSH_SX2;
   logic                  X2_STALL_SX3;
   logic [XLEN-1:0]       RES_RX2;
   logic [TAGW-1:0]       TAG_RX2;
   logic                  RES_VALID_SX2;

   modport master (
      output RES_RX1, SELECT_MSB_RX1, TAG_RX1, X1X2_EMPTY_SX1, FLUSH_SX2, X2_STALL_SX3,
      input  X1X2_POP_SX2, RES_RX2, TAG_RX2, RES_VALID_SX2
   );

   modport slave (
      input  RES_RX1, SELECT_MSB_RX1, TAG_RX1, X1X2_EMPTY_SX1, FLUSH_SX2, X2_STALL_SX3,
      output X1X2_POP_SX2, RES_RX2, TAG_RX2, RES_VALID_SX2
   );
endinterface

// File: rtl/x2_mul_reduce.sv
// Multiplier stage 2: sums partial products, selects a half, queues result+tag in a
// DEPTH-entry buffer. Optional perf counters enabled by `define X2_MUL_PERF_EN.
module x2_mul_reduce #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NPP   = 2,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned TAGW  = 6
) (
   input  logic              clk,
   input  logic              reset,
`ifdef X2_MUL_PERF_EN
   output logic [31:0]       PERF_RES_CNT_SX2,
   output logic [31:0]       PERF_STALL_CNT_SX2,
`endif
   x2_mul_reduce_if.slave    bus
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   typedef logic [PtrW-1:0] ptr_t;
   typedef logic [CntW-1:0] cnt_t;

   logic [2*XLEN-1:0] sum;
   logic [XLEN-1:0]   sel_res;
   logic              full, valid, pop, deq;
   ptr_t              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   cnt_t              count_q, count_d;
   logic [XLEN-1:0]   res_mem_q [DEPTH];
   logic [TAGW-1:0]   tag_mem_q [DEPTH];

   // Carries past bit 2*XLEN-1 fall off naturally; signedness lives in the partials.
   always_comb begin
      sum = '0;
      for (int unsigned k = 0; k < NPP; k++) begin
         sum = sum + bus.RES_RX1[k*2*XLEN +: 2*XLEN];
      end
      sel_res = bus.SELECT_MSB_RX1 ? sum[2*XLEN-1:XLEN] : sum[XLEN-1:0];
   end

   assign full  = (count_q == cnt_t'(DEPTH));
   assign valid = (count_q != '0);
   // No stall term here: a full buffer costs one bubble instead of a stall->pop path.
   assign pop   = !bus.X1X2_EMPTY_SX1 && !full && !bus.FLUSH_SX2 && !reset;
   assign deq   = valid && !bus.X2_STALL_SX3;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (bus.FLUSH_SX2) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (pop) wr_ptr_d = wr_ptr_q + ptr_t'(1);
         if (deq) rd_ptr_d = rd_ptr_q + ptr_t'(1);
         if (pop && !deq) begin
            count_d = count_q + cnt_t'(1);
         end else if (!pop && deq) begin
            count_d = count_q - cnt_t'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (pop) begin
         res_mem_q[wr_ptr_q] <= sel_res;
         tag_mem_q[wr_ptr_q] <= bus.TAG_RX1;
      end
   end

   assign bus.X1X2_POP_SX2  = pop;
   assign bus.RES_VALID_SX2 = valid;
   assign bus.RES_RX2       = valid ? res_mem_q[rd_ptr_q] : '0;
   assign bus.TAG_RX2       = valid ? tag_mem_q[rd_ptr_q] : '0;

`ifdef X2_MUL_PERF_EN
   logic [31:0] perf_res_q, perf_stall_q;

   // Flush does not clear these; a dequeue in the flush cycle still counts.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_res_q   <= '0;
         perf_stall_q <= '0;
      end else begin
         if (deq) perf_res_q <= perf_res_q + 32'd1;
         if (valid && bus.X2_STALL_SX3) perf_stall_q <= perf_stall_q + 32'd1;
      end
   end

   assign PERF_RES_CNT_SX2   = perf_res_q;
   assign PERF_STALL_CNT_SX2 = perf_stall_q;
`endif

endmodule

// File: tb/tb_x2_mul_reduce.sv
// Bench for x2_mul_reduce: directed scenarios then random traffic, all checked against a
// queue-based model of the result buffer.
module tb_x2_mul_reduce;
   localparam int unsigned XLEN  = 32;
   localparam int unsigned NPP   = 2;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned TAGW  = 6;

   typedef struct {
      logic [XLEN-1:0] res;
      logic [TAGW-1:0] tag;
   } ent_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   x2_mul_reduce_if #(.XLEN(XLEN), .NPP(NPP), .TAGW(TAGW)) bus ();

`ifdef X2_MUL_PERF_EN
   logic [31:0] perf_res, perf_stall;
`endif

   x2_mul_reduce #(.XLEN(XLEN), .NPP(NPP), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
      .clk                (clk),
      .reset              (reset),
`ifdef X2_MUL_PERF_EN
      .PERF_RES_CNT_SX2   (perf_res),
      .PERF_STALL_CNT_SX2 (perf_stall),
`endif
      .bus                (bus)
   );

   int   checks = 0;
   int   passed = 0;
   int   fails  = 0;
   ent_t q[$];
   int unsigned m_res_cnt = 0, m_stall_cnt = 0;
   logic last_pop;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic set_bundle(input logic [63:0] p0, input logic [63:0] p1, input logic msb,
                             input logic [TAGW-1:0] tag);
      bus.RES_RX1        = {p1, p0};
      bus.SELECT_MSB_RX1 = msb;
      bus.TAG_RX1        = tag;
   endtask

   task automatic rand_bundle();
      set_bundle({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), TAGW'($urandom));
   endtask

   // One clock: compare DUT against the model, then advance the model at the edge.
   task automatic step(input string tag);
      logic        exp_pop, deq;
      logic [63:0] s;
      ent_t        e;
      @(negedge clk);
      exp_pop = !bus.X1X2_EMPTY_SX1 && (q.size() < DEPTH) && !bus.FLUSH_SX2 && !reset;
      check({tag, ".pop"}, 64'(bus.X1X2_POP_SX2), 64'(exp_pop));
      check({tag, ".valid"}, 64'(bus.RES_VALID_SX2), 64'(q.size() != 0));
      check({tag, ".res"}, 64'(bus.RES_RX2), (q.size() != 0) ? 64'(q[0].res) : 64'd0);
      check({tag, ".tag"}, 64'(bus.TAG_RX2), (q.size() != 0) ? 64'(q[0].tag) : 64'd0);
`ifdef X2_MUL_PERF_EN
      check({tag, ".perf_res"}, 64'(perf_res), 64'(m_res_cnt));
      check({tag, ".perf_stall"}, 64'(perf_stall), 64'(m_stall_cnt));
`endif
      last_pop = bus.X1X2_POP_SX2;
      s = 64'd0;
      for (int k = 0; k < int'(NPP); k++) s = s + bus.RES_RX1[k*64 +: 64];
      e.res = bus.SELECT_MSB_RX1 ? s[63:32] : s[31:0];
      e.tag = bus.TAG_RX1;
      @(posedge clk);
      if (reset) begin
         q.delete();
         m_res_cnt   = 0;
         m_stall_cnt = 0;
      end else begin
         deq = (q.size() != 0) && !bus.X2_STALL_SX3;
         if (deq) m_res_cnt++;
         if ((q.size() != 0) && bus.X2_STALL_SX3) m_stall_cnt++;
         if (bus.FLUSH_SX2) q.delete();
         else begin
            if (deq) void'(q.pop_front());
            if (exp_pop) q.push_back(e);
         end
      end
      #1;
   endtask

   initial begin
      int np;
      logic [4:0] stall_pat;
      reset                = 1'b1;
      bus.X1X2_EMPTY_SX1   = 1'b1;
      bus.FLUSH_SX2        = 1'b0;
      bus.X2_STALL_SX3     = 1'b0;
      set_bundle(64'd0, 64'd0, 1'b0, '0);
      step("rst");
      step("rst");
      reset = 1'b0;

      // Single op, lower half
      set_bundle(64'h0000_0001_0000_0003, 64'h0000_0000_FFFF_FFFF, 1'b0, 6'd5);
      bus.X1X2_EMPTY_SX1 = 1'b0;
      step("t1");
      bus.X1X2_EMPTY_SX1 = 1'b1;
      check("t1.res_const", 64'(bus.RES_RX2), 64'h2);
      check("t1.tag_const", 64'(bus.TAG_RX2), 64'd5);
      check("t1.valid_const", 64'(bus.RES_VALID_SX2), 64'd1);
      step("t1b");

      // Upper half with carry drop
      set_bundle(64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 1'b1, 6'd9);
      bus.X1X2_EMPTY_SX1 = 1'b0;
      step("t2");
      bus.X1X2_EMPTY_SX1 = 1'b1;
      check("t2.res_const", 64'(bus.RES_RX2), 64'h0);
      check("t2.tag_const", 64'(bus.TAG_RX2), 64'd9);
      step("t2b");

      // Backpressure: 4 bundles, stall held
      bus.X2_STALL_SX3   = 1'b1;
      bus.X1X2_EMPTY_SX1 = 1'b0;
      rand_bundle();
      np = 0;
      for (int i = 0; i < 4; i++) begin
         step("bp");
         if (last_pop) begin np++; rand_bundle(); end
      end
      check("bp.pops_stalled", 64'(np), 64'd2);
      bus.X2_STALL_SX3 = 1'b0;
      for (int i = 0; i < 10 && np < 4; i++) begin
         step("bp_rel");
         if (last_pop) begin np++; rand_bundle(); end
         if (np >= 4) bus.X1X2_EMPTY_SX1 = 1'b1;
      end
      check("bp.pops_total", 64'(np), 64'd4);
      bus.X1X2_EMPTY_SX1 = 1'b1;
      for (int i = 0; i < 3; i++) step("bp_drain");

      // Flush with 2 entries buffered
      bus.X2_STALL_SX3   = 1'b1;
      bus.X1X2_EMPTY_SX1 = 1'b0;
      step("fl_fill");
      rand_bundle();
      step("fl_fill");
      bus.FLUSH_SX2 = 1'b1;
      step("fl");
      bus.FLUSH_SX2 = 1'b0;
      check("fl.valid_after", 64'(bus.RES_VALID_SX2), 64'd0);
      bus.X2_STALL_SX3 = 1'b0;
      rand_bundle();
      step("fl_new");
      bus.X1X2_EMPTY_SX1 = 1'b1;
      check("fl.new_valid", 64'(bus.RES_VALID_SX2), 64'd1);
      step("fl_drain");

      // Reset while full
      bus.X2_STALL_SX3   = 1'b1;
      bus.X1X2_EMPTY_SX1 = 1'b0;
      for (int i = 0; i < 3; i++) begin rand_bundle(); step("mr_fill"); end
      reset = 1'b1;
      step("mr");
      check("mr.valid", 64'(bus.RES_VALID_SX2), 64'd0);
      check("mr.res", 64'(bus.RES_RX2), 64'd0);
      check("mr.tag", 64'(bus.TAG_RX2), 64'd0);
      check("mr.pop", 64'(bus.X1X2_POP_SX2), 64'd0);
`ifdef X2_MUL_PERF_EN
      check("mr.perf_res", 64'(perf_res), 64'd0);
      check("mr.perf_stall", 64'(perf_stall), 64'd0);
`endif
      reset = 1'b0;
      bus.X1X2_EMPTY_SX1 = 1'b1;
      bus.X2_STALL_SX3   = 1'b0;
      step("mr_post");

      // 3 results, 2 stall cycles on the head
      stall_pat = 5'b00111;
      np = 0;
      rand_bundle();
      for (int i = 0; i < 7; i++) begin
         bus.X2_STALL_SX3   = (i < 5) ? stall_pat[i] : 1'b0;
         bus.X1X2_EMPTY_SX1 = (np >= 3);
         step("pf");
         if (last_pop) begin np++; rand_bundle(); end
      end
      check("pf.pops", 64'(np), 64'd3);
`ifdef X2_MUL_PERF_EN
      check("pf.perf_res_const", 64'(perf_res), 64'd3);
      check("pf.perf_stall_const", 64'(perf_stall), 64'd2);
`endif

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         rand_bundle();
         bus.X1X2_EMPTY_SX1 = ($urandom_range(0, 3) == 0);
         bus.X2_STALL_SX3   = ($urandom_range(0, 2) == 0);
         bus.FLUSH_SX2      = ($urandom_range(0, 19) == 0);
         reset              = ($urandom_range(0, 49) == 0);
         step("rnd");
      end
      reset         = 1'b0;
      bus.FLUSH_SX2 = 1'b0;
      step("end");

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
